// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoded register fields in, stall/flush/forward controls and counters out
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic              ex_wr_en;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_is_load;
   logic              mem_wr_en;
   logic [REG_AW-1:0] mem_rd;
   logic              branch_taken;
   logic              stall;
   logic              bubble;
   logic              flush;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_wr_en, ex_rd, ex_is_load,
             mem_wr_en, mem_rd, branch_taken,
      input  stall, bubble, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_wr_en, ex_rd, ex_is_load,
             mem_wr_en, mem_rd, branch_taken,
      output stall, bubble, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detection, forwarding select, branch flush and perf counters
module pipe_hazard_ctrl #(
   parameter int REG_AW        = 5,
   parameter int FWD_EN        = 1,
   parameter int ZERO_REG_HARD = 1,
   parameter int CNT_W         = 32
) (
   input logic             clk,
   input logic             rst,
   pipe_hazard_ctrl_if.slave hz
);
   logic [1:0]       cnt_q, cnt_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             ma_ex, mb_ex, ma_mem, mb_mem, any_ex, any_mem;
   logic [1:0]       need, sel_a, sel_b;
   logic             stall_c, flush_c;

   function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r);
      return we && rd == r && !(ZERO_REG_HARD != 0 && r == '0);
   endfunction

   // hazard detection, stall countdown, forward selection and counter next-state
   always_comb begin
      ma_ex       = hz.id_use_rs && hit(hz.ex_wr_en, hz.ex_rd, hz.id_rs);
      mb_ex       = hz.id_use_rt && hit(hz.ex_wr_en, hz.ex_rd, hz.id_rt);
      ma_mem      = hz.id_use_rs && hit(hz.mem_wr_en, hz.mem_rd, hz.id_rs);
      mb_mem      = hz.id_use_rt && hit(hz.mem_wr_en, hz.mem_rd, hz.id_rt);
      any_ex      = ma_ex || mb_ex;
      any_mem     = ma_mem || mb_mem;
      need        = (FWD_EN != 0) ? ((hz.ex_is_load && any_ex) ? 2'd1 : 2'd0)
                                  : (any_ex ? 2'd2 : any_mem ? 2'd1 : 2'd0);
      flush_c     = rst && hz.branch_taken;
      stall_c     = rst && !hz.branch_taken && (cnt_q != 2'd0 || need != 2'd0);
      cnt_d       = hz.branch_taken ? 2'd0
                  : (cnt_q == 2'd0) ? ((need != 2'd0) ? need - 2'd1 : 2'd0)
                  : cnt_q - 2'd1;
      sel_a       = (ma_ex && !hz.ex_is_load) ? 2'b01 : ma_mem ? 2'b10 : 2'b00;
      sel_b       = (mb_ex && !hz.ex_is_load) ? 2'b01 : mb_mem ? 2'b10 : 2'b00;
      fwd_a_d     = (stall_c || flush_c || FWD_EN == 0) ? 2'b00 : sel_a;
      fwd_b_d     = (stall_c || flush_c || FWD_EN == 0) ? 2'b00 : sel_b;
      stall_cnt_d = (stall_c && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_c && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   // state registers, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         fwd_a_q     <= '0;
         fwd_b_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall     = stall_c;
   assign hz.bubble    = stall_c;
   assign hz.flush     = flush_c;
   assign hz.fwd_a_sel = fwd_a_q;
   assign hz.fwd_b_sel = fwd_b_q;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving a stall-only and a forwarding instance
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if i0 ();
   pipe_hazard_ctrl_if i1 ();

   pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .ZERO_REG_HARD(1), .CNT_W(32)) u0 (.clk(clk), .rst(rst), .hz(i0));
   pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .ZERO_REG_HARD(1), .CNT_W(32)) u1 (.clk(clk), .rst(rst), .hz(i1));

   typedef struct {
      int          tag;
      int          d;
      logic        st;
      logic        fl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   step  = 0;

   // monitor: every output sample point, pop all pending expectations and compare
   always @(negedge clk) begin
      while (q.size() != 0) begin
         exp_t e;
         logic        st, bu, fl;
         logic [1:0]  fa, fb;
         logic [31:0] sc, fc;
         e  = q.pop_front();
         st = e.d ? i1.stall     : i0.stall;
         bu = e.d ? i1.bubble    : i0.bubble;
         fl = e.d ? i1.flush     : i0.flush;
         fa = e.d ? i1.fwd_a_sel : i0.fwd_a_sel;
         fb = e.d ? i1.fwd_b_sel : i0.fwd_b_sel;
         sc = e.d ? i1.stall_cnt : i0.stall_cnt;
         fc = e.d ? i1.flush_cnt : i0.flush_cnt;
         n_chk++;
         if (st !== e.st || bu !== e.st || fl !== e.fl || fa !== e.fa || fb !== e.fb || sc !== e.sc || fc !== e.fc) begin
            n_err++;
            $display("FAIL step%0d dut%0d: got st=%b bu=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d, want st=%b bu=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d",
                     e.tag, e.d, st, bu, fl, fa, fb, sc, fc, e.st, e.st, e.fl, e.fa, e.fb, e.sc, e.fc);
         end
      end
   end

   task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                      input logic exw, input logic [4:0] exrd, input logic exld,
                      input logic memw, input logic [4:0] memrd, input logic bt);
      @(posedge clk);
      #1;
      i0.id_rs = rs;     i1.id_rs = rs;
      i0.id_rt = rt;     i1.id_rt = rt;
      i0.id_use_rs = urs; i1.id_use_rs = urs;
      i0.id_use_rt = urt; i1.id_use_rt = urt;
      i0.ex_wr_en = exw; i1.ex_wr_en = exw;
      i0.ex_rd = exrd;   i1.ex_rd = exrd;
      i0.ex_is_load = exld; i1.ex_is_load = exld;
      i0.mem_wr_en = memw; i1.mem_wr_en = memw;
      i0.mem_rd = memrd; i1.mem_rd = memrd;
      i0.branch_taken = bt; i1.branch_taken = bt;
      step++;
   endtask

   task automatic idle();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic ex(input int d, input logic st, input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                     input int sc, input int fc);
      exp_t e;
      e.tag = step; e.d = d; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
      q.push_back(e);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      ex(0, 0, 0, 2'b00, 2'b00, 0, 0);
      ex(1, 0, 0, 2'b00, 2'b00, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      do_reset();
      // stall-only: EX producer -> two stall cycles
      drv(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 5'd0, 0); ex(0, 1, 0, 2'b00, 2'b00, 0, 0);
      drv(5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 1, 5'd3, 0); ex(0, 1, 0, 2'b00, 2'b00, 1, 0);
      drv(5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'd0, 0); ex(0, 0, 0, 2'b00, 2'b00, 2, 0);
      idle();                                         ex(0, 0, 0, 2'b00, 2'b00, 2, 0);
      // stall-only: MEM producer -> one stall cycle
      do_reset();
      drv(5'd0, 5'd5, 0, 1, 0, 5'd0, 0, 1, 5'd5, 0); ex(0, 1, 0, 2'b00, 2'b00, 0, 0);
      drv(5'd0, 5'd5, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0); ex(0, 0, 0, 2'b00, 2'b00, 1, 0);
      idle();                                         ex(0, 0, 0, 2'b00, 2'b00, 1, 0);
      // stall-only: sources hit EX and MEM -> larger need (2) wins
      do_reset();
      drv(5'd4, 5'd6, 1, 1, 1, 5'd4, 0, 1, 5'd6, 0); ex(0, 1, 0, 2'b00, 2'b00, 0, 0);
      drv(5'd4, 5'd6, 1, 1, 0, 5'd0, 0, 1, 5'd4, 0); ex(0, 1, 0, 2'b00, 2'b00, 1, 0);
      idle();                                         ex(0, 0, 0, 2'b00, 2'b00, 2, 0);
      // forwarding: ALU producer in EX -> 01, then in MEM -> 10
      do_reset();
      drv(5'd7, 5'd7, 1, 1, 1, 5'd7, 0, 0, 5'd0, 0); ex(1, 0, 0, 2'b00, 2'b00, 0, 0);
      idle();                                         ex(1, 0, 0, 2'b01, 2'b01, 0, 0);
      drv(5'd7, 5'd7, 1, 1, 0, 5'd0, 0, 1, 5'd7, 0); ex(1, 0, 0, 2'b00, 2'b00, 0, 0);
      idle();                                         ex(1, 0, 0, 2'b10, 2'b10, 0, 0);
      // forwarding: same register in EX and MEM -> EX wins
      drv(5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 1, 5'd9, 0); ex(1, 0, 0, 2'b00, 2'b00, 0, 0);
      idle();                                         ex(1, 0, 0, 2'b01, 2'b00, 0, 0);
      // forwarding: load-use -> one stall, then MEM forward
      do_reset();
      drv(5'd2, 5'd0, 1, 0, 1, 5'd2, 1, 0, 5'd0, 0); ex(1, 1, 0, 2'b00, 2'b00, 0, 0);
      drv(5'd2, 5'd0, 1, 0, 0, 5'd0, 0, 1, 5'd2, 0); ex(1, 0, 0, 2'b00, 2'b00, 1, 0);
      idle();                                         ex(1, 0, 0, 2'b10, 2'b00, 1, 0);
      // branch taken mid-stall aborts the stall
      do_reset();
      drv(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 5'd0, 0); ex(0, 1, 0, 2'b00, 2'b00, 0, 0);
      drv(5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 1, 5'd3, 1); ex(0, 0, 1, 2'b00, 2'b00, 1, 0);
      idle();                                         ex(0, 0, 0, 2'b00, 2'b00, 1, 1);
      // register 0 is never a hazard source
      do_reset();
      drv(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 1, 5'd0, 0); ex(0, 0, 0, 2'b00, 2'b00, 0, 0); ex(1, 0, 0, 2'b00, 2'b00, 0, 0);
      idle();                                         ex(0, 0, 0, 2'b00, 2'b00, 0, 0); ex(1, 0, 0, 2'b00, 2'b00, 0, 0);
      // reset mid-stall clears everything with no residual stall
      do_reset();
      drv(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 5'd0, 0); ex(0, 1, 0, 2'b00, 2'b00, 0, 0);
      drv(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 5'd0, 0); ex(0, 1, 0, 2'b00, 2'b00, 1, 0);
      drv(5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 1, 5'd3, 0); rst = 1'b0; ex(0, 0, 0, 2'b00, 2'b00, 0, 0);
      idle(); rst = 1'b1;                             ex(0, 0, 0, 2'b00, 2'b00, 0, 0);
      idle();                                         ex(0, 0, 0, 2'b00, 2'b00, 0, 0);
      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
